// File: rtl/seq_pkg.sv
// Shared types and constants for the memory sequencer that couples the
// single-cycle core to one variable-latency memory port.
package seq_pkg;

  typedef enum logic [2:0] {
    ARB,
    FETCH,
    DECODE,
    DATA,
    COMMIT,
    DBG
  } seq_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_sequencer.sv
// Multi-cycle sequencer: fetch, optional load/store, then commit pulse to the
// core; arbitrates the shared memory port with a debug/program-loader requester.
module mem_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              run,
  input  logic [ADDR_W-1:0] core_pc,
  input  logic              core_mem_read,
  input  logic              core_mem_write,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_instr,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_step,
  output logic [31:0]       instret,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  seq_state_e state, state_nxt;
  logic       last_dbg;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= ARB;
    else     state <= state_nxt;
  end

  // Memory port is a pure function of state, so reset drops mem_req at once.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ARB: begin
        if (dbg_req && !dbg_ack && (!last_dbg || !run)) state_nxt = DBG;
        else if (run)                                    state_nxt = FETCH;
      end
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = core_pc;
        if (mem_ack) state_nxt = DECODE;
      end
      DECODE: begin
        state_nxt = (core_mem_read || core_mem_write) ? DATA : COMMIT;
      end
      DATA: begin
        mem_req   = 1'b1;
        mem_we    = core_mem_write;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        if (mem_ack) state_nxt = COMMIT;
      end
      COMMIT: state_nxt = ARB;
      DBG: begin
        mem_req   = 1'b1;
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        if (mem_ack) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  assign core_step = (state == COMMIT);

  // last_dbg forces a core instruction between debug grants while running.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      core_instr <= DATA_W'(NOP_INSTR);
      core_rdata <= '0;
      dbg_rdata  <= '0;
      instret    <= '0;
      dbg_ack    <= 1'b0;
      last_dbg   <= 1'b0;
    end else begin
      dbg_ack <= 1'b0;
      case (state)
        FETCH: if (mem_ack) core_instr <= mem_rdata;
        DATA:  if (mem_ack && !core_mem_write) core_rdata <= mem_rdata;
        COMMIT: begin
          instret  <= instret + 32'd1;
          last_dbg <= 1'b0;
        end
        DBG: begin
          if (mem_ack) begin
            if (!dbg_we) dbg_rdata <= mem_rdata;
            dbg_ack  <= 1'b1;
            last_dbg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench: tiny RV32 core stub and wait-state memory around mem_sequencer.
module tb_mem_sequencer;

  logic        clock = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] core_pc;
  logic        core_mem_read, core_mem_write;
  logic [31:0] core_addr, core_wdata;
  logic [31:0] core_instr, core_rdata;
  logic        core_step;
  logic [31:0] instret;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .rst(rst), .run(run),
    .core_pc(core_pc), .core_mem_read(core_mem_read), .core_mem_write(core_mem_write),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_instr(core_instr), .core_rdata(core_rdata), .core_step(core_step),
    .instret(instret),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Core stub: decodes addi / lw / sw with the register file held here.
  logic [31:0] pc;
  logic [31:0] rf [32];
  logic [6:0]  op;
  logic [31:0] iimm, simm;

  always_comb begin
    op             = core_instr[6:0];
    iimm           = {{20{core_instr[31]}}, core_instr[31:20]};
    simm           = {{20{core_instr[31]}}, core_instr[31:25], core_instr[11:7]};
    core_mem_read  = (op == 7'h03);
    core_mem_write = (op == 7'h23);
    core_addr      = rf[core_instr[19:15]] + (core_mem_write ? simm : iimm);
    core_wdata     = rf[core_instr[24:20]];
    core_pc        = pc;
  end

  always @(posedge clock or posedge rst) begin
    if (rst) begin
      pc <= 32'h0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else if (core_step) begin
      pc <= pc + 32'd4;
      if (op == 7'h13 && core_instr[11:7] != 5'd0)
        rf[core_instr[11:7]] <= rf[core_instr[19:15]] + iimm;
      if (op == 7'h03 && core_instr[11:7] != 5'd0)
        rf[core_instr[11:7]] <= core_rdata;
    end
  end

  // Memory: 256 words, per-address wait states, ack combinational in the final wait cycle.
  logic [31:0] mem [256];
  int          ld_wait;
  int          wcnt = 0;
  int          wr_cnt = 0;
  int          lat;

  assign mem_rdata = mem[mem_addr[9:2]];

  always_comb begin
    lat = 0;
    if (mem_addr == 32'h40)      lat = ld_wait;
    else if (mem_addr == 32'h80) lat = 1;
    mem_ack = mem_req && (wcnt >= lat);
  end

  always @(posedge clock) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
    if (mem_req && mem_we && mem_ack) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  initial begin
    int last_evt, evt, n_d, n_s;
    logic [31:0] inst_at_d;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
    mem[0]  = 32'h0050_0093;   // addi x1,x0,5
    mem[1]  = 32'h0400_2103;   // lw   x2,0x40(x0)
    mem[2]  = 32'h0810_2023;   // sw   x1,0x80(x0)
    mem[16] = 32'hDEAD_BEEF;
    mem[64] = 32'h0;

    rst = 1'b1; run = 1'b0; ld_wait = 2;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
    repeat (2) tick();
    check_val("rst_mem_req", mem_req, 1'b0);
    check_val("rst_mem_addr", mem_addr, 32'h0);
    check_val("rst_instr", core_instr, 32'h13);
    check_val("rst_instret", instret, 32'h0);
    check_val("rst_step", core_step, 1'b0);
    check_val("rst_dbg_ack", dbg_ack, 1'b0);
    check_val("rst_rdata", core_rdata, 32'h0);
    check_val("rst_dbg_rdata", dbg_rdata, 32'h0);

    rst = 1'b0; run = 1'b1;
    tick();  // c1 FETCH
    check_val("f0_req", mem_req, 1'b1);
    check_val("f0_addr", mem_addr, 32'h0);
    check_val("f0_we", mem_we, 1'b0);
    tick();  // c2 DECODE
    check_val("dec0_req", mem_req, 1'b0);
    check_val("dec0_instr", core_instr, 32'h0050_0093);
    tick();  // c3 COMMIT
    check_val("c0_step", core_step, 1'b1);
    check_val("c0_instret", instret, 32'h0);
    tick();  // c4 ARB
    check_val("arb1_step", core_step, 1'b0);
    check_val("arb1_instret", instret, 32'h1);
    check_val("arb1_req", mem_req, 1'b0);
    tick();  // c5 FETCH
    check_val("f1_addr", mem_addr, 32'h4);
    tick();  // c6 DECODE
    check_val("dec1_instr", core_instr, 32'h0400_2103);
    tick();  // c7 DATA wait 1
    check_val("ld_w1_req", mem_req, 1'b1);
    check_val("ld_w1_addr", mem_addr, 32'h40);
    check_val("ld_w1_ack", mem_ack, 1'b0);
    tick();  // c8 DATA wait 2
    check_val("ld_w2_req", mem_req, 1'b1);
    check_val("ld_w2_step", core_step, 1'b0);
    tick();  // c9 DATA ack
    check_val("ld_ack", mem_ack, 1'b1);
    check_val("ld_ack_addr", mem_addr, 32'h40);
    tick();  // c10 COMMIT
    check_val("ld_step", core_step, 1'b1);
    check_val("ld_rdata", core_rdata, 32'hDEAD_BEEF);
    tick();  // c11 ARB
    check_val("ld_instret", instret, 32'h2);
    check_val("ld_step_low", core_step, 1'b0);
    tick();  // c12 FETCH
    check_val("f2_addr", mem_addr, 32'h8);
    tick();  // c13 DECODE
    tick();  // c14 DATA wait
    check_val("st_w_req", mem_req, 1'b1);
    check_val("st_w_we", mem_we, 1'b1);
    check_val("st_w_addr", mem_addr, 32'h80);
    check_val("st_w_wdata", mem_wdata, 32'h5);
    check_val("st_w_ack", mem_ack, 1'b0);
    tick();  // c15 DATA ack
    check_val("st_a_we", mem_we, 1'b1);
    check_val("st_a_addr", mem_addr, 32'h80);
    check_val("st_a_wdata", mem_wdata, 32'h5);
    check_val("st_a_ack", mem_ack, 1'b1);
    tick();  // c16 COMMIT
    check_val("st_step", core_step, 1'b1);
    tick();  // c17 ARB
    check_val("st_instret", instret, 32'h3);
    check_val("st_wr_cnt", wr_cnt, 32'd1);
    check_val("st_mem", mem[32], 32'h5);
    run = 1'b0;

    tick();  // c18 idle
    check_val("idle_req", mem_req, 1'b0);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h100; dbg_wdata = 32'h13;
    tick();  // c19 DBG write
    check_val("dw_req", mem_req, 1'b1);
    check_val("dw_we", mem_we, 1'b1);
    check_val("dw_addr", mem_addr, 32'h100);
    check_val("dw_wdata", mem_wdata, 32'h13);
    check_val("dw_ack_early", dbg_ack, 1'b0);
    tick();  // c20 ARB
    check_val("dw_ack", dbg_ack, 1'b1);
    check_val("dw_req_low", mem_req, 1'b0);
    dbg_req = 1'b0;
    tick();  // c21
    check_val("dw_ack_low", dbg_ack, 1'b0);
    check_val("dw_mem", mem[64], 32'h13);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_wdata = 32'h0;
    tick();  // c22 DBG read
    check_val("dr_req", mem_req, 1'b1);
    check_val("dr_we", mem_we, 1'b0);
    check_val("dr_addr", mem_addr, 32'h100);
    tick();  // c23 ARB
    check_val("dr_ack", dbg_ack, 1'b1);
    check_val("dr_rdata", dbg_rdata, 32'h13);
    dbg_req = 1'b0;
    tick();  // c24
    check_val("dr_ack_low", dbg_ack, 1'b0);
    check_val("dbg_no_fetch", instret, 32'h3);
    check_val("dbg_wr_cnt", wr_cnt, 32'd2);

    run = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h100;
    last_evt = 2; n_d = 0; n_s = 0; inst_at_d = 32'h0;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (dbg_ack || core_step) begin
        evt = dbg_ack ? 1 : 0;
        if (last_evt == 2) check_val("alt_first", evt, 32'd0);
        else               check_val("alt_order", evt, (last_evt == 1) ? 32'd0 : 32'd1);
        last_evt = evt;
        if (dbg_ack) begin
          check_val("alt_dbg_rdata", dbg_rdata, 32'h13);
          if (n_d > 0) check_val("alt_instret", instret, inst_at_d + 32'd1);
          inst_at_d = instret;
          n_d++;
        end else begin
          n_s++;
        end
      end
    end
    check_val("alt_n_dbg", n_d, 32'd8);
    check_val("alt_n_step", n_s, 32'd8);
    dbg_req = 1'b0;

    rst = 1'b1; ld_wait = 5;
    tick();
    rst = 1'b0; run = 1'b1;
    repeat (8) tick();  // c8: second cycle of the load's DATA wait
    check_val("mid_req", mem_req, 1'b1);
    check_val("mid_addr", mem_addr, 32'h40);
    check_val("mid_instret", instret, 32'h1);
    #1 rst = 1'b1;
    #1;
    check_val("arst_req", mem_req, 1'b0);
    check_val("arst_instr", core_instr, 32'h13);
    check_val("arst_instret", instret, 32'h0);
    check_val("arst_step", core_step, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check_val("resume_req", mem_req, 1'b1);
    check_val("resume_addr", mem_addr, 32'h0);
    check_val("resume_instret", instret, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
